// File: rtl/dmem_responder_if.sv
// Load/store request and response bundle between the datapath and
// the data-memory responder.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport slave (
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_err,
        output busy
    );

    modport master (
        output req_valid,
        output req_write,
        output req_addr,
        output req_wdata,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_err,
        input  busy
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data RAM behind a single-outstanding valid/ready
// handshake with a fixed number of wait states.
module dmem_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic             clk,
    input  logic             Reset,
    dmem_responder_if.slave  bus
);
    localparam int WORDS = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT =
        (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic        busy_q;
    logic [31:0] rsp_rdata_q;

    logic [31:0] mem [WORDS];

    logic                  accept;
    logic                  c_write;
    logic [31:0]           c_addr;
    logic [31:0]           c_wdata;
    logic [29:0]           c_word;
    logic [DEPTH_LOG2-1:0] c_idx;
    logic                  c_err;
    logic                  enter_resp;

    // With zero wait states the commit uses the live request,
    // otherwise the copy captured at acceptance.
    always_comb begin
        accept     = (state == S_IDLE) && bus.req_valid;
        c_write    = accept ? bus.req_write : write_q;
        c_addr     = accept ? bus.req_addr  : addr_q;
        c_wdata    = accept ? bus.req_wdata : wdata_q;
        c_word     = c_addr[31:2];
        c_idx      = c_word[DEPTH_LOG2-1:0];
        c_err      = (c_addr[1:0] != 2'b00) ||
                     ((c_word >> DEPTH_LOG2) != '0);
        enter_resp = (accept && (LATENCY == 0)) ||
                     ((state == S_WAIT) && (cnt == 4'd0));
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        write_q     <= bus.req_write;
                        addr_q      <= bus.req_addr;
                        wdata_q     <= bus.req_wdata;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (LATENCY != 0) begin
                            state <= S_WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (enter_resp) begin
                state       <= S_RESP;
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= c_err;
                rsp_rdata_q <= (!c_err && !c_write) ? mem[c_idx] : '0;
                if (!c_err && c_write) begin
                    mem[c_idx] <= c_wdata;
                end
            end
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a plain array model,
// covering LATENCY=2 and LATENCY=0 builds.
module tb_dmem_responder;
    localparam int WORDS = 256;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    dmem_responder_if bus_a ();
    dmem_responder_if bus_b ();

    dmem_responder #(.DEPTH_LOG2(8), .LATENCY(2)) u_dut_a (
        .clk   (clk),
        .Reset (rst_a),
        .bus   (bus_a.slave)
    );

    dmem_responder #(.DEPTH_LOG2(8), .LATENCY(0)) u_dut_b (
        .clk   (clk),
        .Reset (rst_b),
        .bus   (bus_b.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] ref_mem   [2][WORDS];
    bit          ref_known [2][WORDS];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit ref_err(input logic [31:0] a);
        return ((a % 4) != 0) || ((a / 4) >= WORDS);
    endfunction

    task automatic idle_inputs(input virtual dmem_responder_if v);
        v.req_valid = 1'b0;
        v.req_write = 1'b0;
        v.req_addr  = '0;
        v.req_wdata = '0;
        v.rsp_ready = 1'b1;
    endtask

    task automatic chk_reset(input virtual dmem_responder_if v);
        chk("rst_req_ready", v.req_ready, 1);
        chk("rst_rsp_valid", v.rsp_valid, 0);
        chk("rst_rsp_rdata", v.rsp_rdata, 0);
        chk("rst_rsp_err",   v.rsp_err,   0);
        chk("rst_busy",      v.busy,      0);
    endtask

    task automatic txn(input int d, input bit wr,
                       input logic [31:0] addr,
                       input logic [31:0] wdata, input int hold);
        virtual dmem_responder_if v;
        int          lat;
        int          n;
        bit          e;
        bit          chk_rd;
        logic [31:0] exp_rd;
        if (d == 0) begin
            v   = bus_a;
            lat = 2;
        end else begin
            v   = bus_b;
            lat = 0;
        end
        e      = ref_err(addr);
        exp_rd = '0;
        chk_rd = 1'b1;
        if (!wr && !e) begin
            chk_rd = ref_known[d][addr / 4];
            exp_rd = ref_mem[d][addr / 4];
        end
        @(negedge clk);
        n = 0;
        while (!v.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_idle", v.req_ready, 1);
        v.rsp_ready = (hold == 0);
        v.req_valid = 1'b1;
        v.req_write = wr;
        v.req_addr  = addr;
        v.req_wdata = wdata;
        @(posedge clk);
        #1;
        v.req_valid = 1'b0;
        v.req_write = 1'($urandom);
        v.req_addr  = $urandom;
        v.req_wdata = $urandom;
        n = 0;
        while (!v.rsp_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n, lat);
        chk("rsp_valid", v.rsp_valid, 1);
        chk("rsp_err", v.rsp_err, e);
        if (chk_rd) chk("rsp_rdata", v.rsp_rdata, exp_rd);
        chk("busy_resp", v.busy, 1);
        chk("req_ready_resp", v.req_ready, 0);
        for (int i = 0; i < hold; i++) begin
            v.req_valid = ~v.req_valid;
            v.req_addr  = $urandom;
            @(posedge clk);
            #1;
            chk("hold_valid", v.rsp_valid, 1);
            if (chk_rd) chk("hold_rdata", v.rsp_rdata, exp_rd);
            chk("hold_err", v.rsp_err, e);
            chk("hold_req_ready", v.req_ready, 0);
            chk("hold_busy", v.busy, 1);
        end
        v.req_valid = 1'b0;
        v.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("done_valid", v.rsp_valid, 0);
        chk("done_req_ready", v.req_ready, 1);
        chk("done_busy", v.busy, 0);
        chk("done_rdata", v.rsp_rdata, 0);
        chk("done_err", v.rsp_err, 0);
        if (wr && !e) begin
            ref_mem[d][addr / 4]   = wdata;
            ref_known[d][addr / 4] = 1'b1;
        end
    endtask

    // Store on DUT A, then reset 'edges' clocks after acceptance;
    // the store lands only if RESP was reached before reset.
    task automatic store_reset(input logic [31:0] addr,
                               input logic [31:0] wdata,
                               input int edges);
        @(negedge clk);
        bus_a.rsp_ready = 1'b0;
        bus_a.req_valid = 1'b1;
        bus_a.req_write = 1'b1;
        bus_a.req_addr  = addr;
        bus_a.req_wdata = wdata;
        @(posedge clk);
        #1;
        bus_a.req_valid = 1'b0;
        bus_a.req_addr  = $urandom;
        bus_a.req_wdata = $urandom;
        repeat (edges) @(posedge clk);
        #1;
        rst_a = 1'b1;
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        bus_a.rsp_ready = 1'b1;
        chk_reset(bus_a);
        if (edges >= 2) begin
            ref_mem[0][addr / 4]   = wdata;
            ref_known[0][addr / 4] = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < WORDS; w++) begin
                ref_known[d][w] = 1'b0;
                ref_mem[d][w]   = '0;
            end
        idle_inputs(bus_a);
        idle_inputs(bus_b);
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset(bus_a);
        chk_reset(bus_b);
        rst_a = 1'b0;
        rst_b = 1'b0;

        txn(0, 1'b1, 32'h10, 32'h1234_5678, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 0);

        txn(0, 1'b1, 32'h0, 32'hA5A5_A5A5, 0);
        txn(0, 1'b0, 32'h13, 32'h0, 0);
        txn(0, 1'b1, 32'h400, 32'hFFFF_FFFF, 0);
        txn(0, 1'b0, 32'h0, 32'h0, 0);

        txn(0, 1'b0, 32'h10, 32'h0, 5);

        txn(1, 1'b1, 32'h3FC, 32'hDEAD_BEEF, 0);
        txn(1, 1'b0, 32'h3FC, 32'h0, 0);
        txn(1, 1'b0, 32'h3FD, 32'h0, 0);

        txn(0, 1'b1, 32'h20, 32'h1111_1111, 0);
        store_reset(32'h20, 32'hCAFE_F00D, 0);
        txn(0, 1'b0, 32'h20, 32'h0, 0);
        store_reset(32'h20, 32'hCAFE_F00D, 1);
        txn(0, 1'b0, 32'h20, 32'h0, 0);
        store_reset(32'h24, 32'h0000_0077, 3);
        txn(0, 1'b0, 32'h24, 32'h0, 0);

        txn(0, 1'b1, 32'h40, 32'h55, 0);
        txn(0, 1'b0, 32'h40, 32'h0, 0);

        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7)
                a = 32'($urandom_range(0, 31)) << 2;
            else if (r == 7)
                a = (32'($urandom_range(0, 255)) << 2) |
                    32'($urandom_range(1, 3));
            else
                a = ($urandom | 32'h400) & 32'hFFFF_FFFC;
            txn(0, 1'($urandom), a, $urandom,
                ($urandom_range(0, 7) == 0) ? 2 : 0);
        end
        for (int i = 0; i < 20; i++) begin
            a = 32'($urandom_range(0, 15)) << 2;
            txn(1, 1'($urandom), a, $urandom, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
